// File: rtl/bcd_seg7_pkg.sv
// Shared types and constants for the BCD 7-segment scan driver.
//   state_e       : scan FSM states (INIT, DRIVE, GAP)
//   SEG_0..SEG_9  : active-high segment patterns {g,f,e,d,c,b,a}
//   SEG_DASH      : pattern shown for non-BCD nibbles (segment g only)
//   presc_width() : width of a counter that holds 0..scan_div-1
package bcd_seg7_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    function automatic int presc_width(input int scan_div);
        return (scan_div > 1) ? $clog2(scan_div) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder, active-high output.
//   bcd : 4-bit digit code
//   seg : {g,f,e,d,c,b,a}; codes A..F produce a dash (segment g)
module bcd_to_seg7
    import bcd_seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver for packed BCD digits.
// Loaded values are double-buffered and only take effect at a frame
// boundary; each digit is driven SCAN_DIV cycles followed by a one-cycle
// dark gap.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   load       : capture bcd_in this cycle
//   bcd_in     : packed BCD, nibble 0 = least significant digit
//   blank      : force all anodes inactive
//   seg        : segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   an         : digit enables, polarity per AN_ACTIVE_LOW
//   frame_done : one-cycle pulse when the scan wraps to digit 0
//   err        : sticky, set by any load carrying a nibble > 9
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module bcd_seg7_scan_driver
    import bcd_seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    err
);

    localparam int PW = presc_width(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    // XOR masks: an active-high "on" pattern becomes the pin value.
    localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    state_e                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;
    logic                    err_q, err_d;

    logic                    wrap;
    logic                    bad_code;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [NUM_DIGITS-1:0]   lz_hide;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= INIT;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = DRIVE;
            DRIVE:   if (presc_q == PRESC_LAST) state_d = GAP;
            GAP:     state_d = DRIVE;
            default: state_d = INIT;
        endcase
    end

    // ---------------- datapath next values ----------------
    assign wrap = (state_q == GAP) && (idx_q == IDX_LAST);

    always_comb begin
        bad_code = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd_in[4*i +: 4] > 4'd9) bad_code = 1'b1;
    end

    always_comb begin
        presc_d      = (state_q == DRIVE && presc_q != PRESC_LAST) ? presc_q + PW'(1) : '0;
        idx_d        = idx_q;
        if (state_q == GAP) idx_d = wrap ? '0 : idx_q + IW'(1);

        pending_d    = pending_q;
        active_d     = active_q;
        pend_valid_d = pend_valid_q;
        // A load on the wrap cycle bypasses pending and lands straight in
        // the buffer the next frame will display.
        if (wrap) begin
            if (load)              active_d = bcd_in;
            else if (pend_valid_q) active_d = pending_q;
            pend_valid_d = 1'b0;
        end else if (load) begin
            pending_d    = bcd_in;
            pend_valid_d = 1'b1;
        end

        err_d = err_q | (load & bad_code);
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cur_nib = active_q[3:0];
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx_q == IW'(i)) cur_nib = active_q[4*i +: 4];
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit i>0 is hidden when it and every more-significant digit are 0.
    logic all_zero;
    always_comb begin
        lz_hide  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero && (active_q[4*i +: 4] == 4'd0);
            lz_hide[i] = all_zero;
        end
    end
`else
    assign lz_hide = '0;
`endif

    always_comb begin
        seg_on = 7'h00;
        an_on  = '0;
        if (state_q == DRIVE) begin
            seg_on = dec_seg;
            for (int i = 0; i < NUM_DIGITS; i++)
                an_on[i] = (idx_q == IW'(i));
            an_on = an_on & ~lz_hide;
            if (blank) an_on = '0;
        end
        seg_d = seg_on ^ SEG_POL;
        an_d  = an_on ^ AN_POL;
        fd_d  = wrap;
    end

    // ---------------- datapath / output registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            active_q     <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_POL;
            an_q         <= AN_POL;
            fd_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            fd_q         <= fd_d;
            err_q        <= err_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
// Directed bench for bcd_seg7_scan_driver (NUM_DIGITS=2, SCAN_DIV=4,
// active-low seg and an). Frame = 10 cycles: after a frame_done sample
// (offset 0), offsets 1-4 show digit 0, 5 is the gap, 6-9 digit 1, and
// offset 10 is the gap carrying the next frame_done.
module tb_bcd_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       blank = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_done;
    logic       err;

    int total = 0;
    int bad   = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    bcd_seg7_scan_driver #(
        .NUM_DIGITS     (2),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .bcd_in     (bcd_in),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] s0;
        logic [6:0] s1;
        logic       e;
    } vec_t;
    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic chk_seg(input string name, input logic [6:0] on_pat);
        logic [6:0] w;
        w = ~on_pat;
        chk(name, {1'b0, seg}, {1'b0, w});
    endtask

    // Advance until frame_done is seen; leaves the bench at offset 0.
    task automatic sync();
        int n;
        n = 0;
        step();
        while (frame_done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (frame_done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL sync: frame_done not seen within 30 cycles");
        end
    endtask

    // Checks offsets 1..10 of one frame, starting from offset 0.
    task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1, input logic hide1);
        logic [1:0] ea;
        for (int off = 1; off <= 10; off++) begin
            step();
            if (off <= 4)                ea = 2'b10;
            else if (off >= 6 && off <= 9) ea = hide1 ? 2'b11 : 2'b01;
            else                         ea = 2'b11;
            chk("an", {6'b0, an}, {6'b0, ea});
            if (off <= 4) chk_seg("seg digit0", s0);
            if (off >= 6 && off <= 9 && !hide1) chk_seg("seg digit1", s1);
            chk("frame_done", {7'b0, frame_done}, {7'b0, (off == 10)});
        end
    endtask

    initial begin
        vecs[0] = '{8'h42, 7'h5B, 7'h66, 1'b0};
        vecs[1] = '{8'h90, 7'h3F, 7'h6F, 1'b0};
        vecs[2] = '{8'h85, 7'h6D, 7'h7F, 1'b0};
        vecs[3] = '{8'h07, 7'h07, 7'h3F, 1'b0};
        vecs[4] = '{8'h00, 7'h3F, 7'h3F, 1'b0};
        vecs[5] = '{8'h3C, 7'h40, 7'h4F, 1'b1};
        vecs[6] = '{8'h61, 7'h06, 7'h7D, 1'b1};
        vecs[7] = '{8'hF0, 7'h3F, 7'h40, 1'b1};

        // Reset state
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst seg", {1'b0, seg}, 8'h7F);
        chk("rst an", {6'b0, an}, 8'h03);
        chk("rst frame_done", {7'b0, frame_done}, 8'h00);
        chk("rst err", {7'b0, err}, 8'h00);
        reset = 1'b1;
        sync();

        // Table: load at offset 0 (goes to pending), shown from next frame
        for (int i = 0; i < 8; i++) begin
            bcd_in = vecs[i].bcd;
            load   = 1'b1;
            step();
            load   = 1'b0;
            sync();
            chk("err", {7'b0, err}, {7'b0, vecs[i].e});
            check_frame(vecs[i].s0, vecs[i].s1, LZ && (vecs[i].bcd[7:4] == 4'h0));
        end

        // Tearing: two loads inside a frame showing F0; last one wins next frame
        bcd_in = 8'h42; load = 1'b1; step(); load = 1'b0;     // offset 1
        chk("tear an d0", {6'b0, an}, 8'h02);
        chk_seg("tear seg d0 old", 7'h3F);
        repeat (4) step();                                    // offset 5
        bcd_in = 8'h99; load = 1'b1; step(); load = 1'b0;     // offset 6
        chk("tear an d1", {6'b0, an}, 8'h01);
        chk_seg("tear seg d1 old", 7'h40);
        repeat (3) step();                                    // offset 9
        chk_seg("tear seg d1 old late", 7'h40);
        step();                                               // offset 10
        chk("tear frame_done", {7'b0, frame_done}, 8'h01);
        check_frame(7'h6F, 7'h6F, 1'b0);
        chk("err sticky", {7'b0, err}, 8'h01);

        // Blank for 7 cycles mid-DRIVE; cadence and digit order unaffected
        repeat (2) step();                                    // offset 2
        blank = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();                                           // offsets 3..9
            chk("blank an", {6'b0, an}, 8'h03);
        end
        blank = 1'b0;
        step();                                               // offset 10
        chk("blank frame_done", {7'b0, frame_done}, 8'h01);
        check_frame(7'h6F, 7'h6F, 1'b0);

        // Load on the wrap cycle goes directly into active
        repeat (9) step();                                    // offset 9 (GAP state)
        bcd_in = 8'h27; load = 1'b1; step(); load = 1'b0;     // offset 10
        chk("wrap-load frame_done", {7'b0, frame_done}, 8'h01);
        check_frame(7'h07, 7'h5B, 1'b0);

        // Reset in the middle of GAP with data pending
        bcd_in = 8'h55; load = 1'b1; step(); load = 1'b0;     // offset 1
        repeat (3) step();                                    // offset 4 (GAP state)
        reset = 1'b0;
        #1;
        chk("midrst seg", {1'b0, seg}, 8'h7F);
        chk("midrst an", {6'b0, an}, 8'h03);
        chk("midrst err", {7'b0, err}, 8'h00);
        chk("midrst frame_done", {7'b0, frame_done}, 8'h00);
        step();
        reset = 1'b1;
        step();
        chk("post-rst INIT an", {6'b0, an}, 8'h03);
        step();
        chk("post-rst an d0", {6'b0, an}, 8'h02);
        chk_seg("post-rst seg d0", 7'h3F);
        repeat (5) step();
        chk("post-rst an d1", {6'b0, an}, LZ ? 8'h03 : 8'h01);
        if (!LZ) chk_seg("post-rst seg d1", 7'h3F);
        sync();
        check_frame(7'h3F, 7'h3F, LZ);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
